// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: countdown scoreboard of in-flight register writes driving stall and its cause.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_dst,
    input  logic              id_mem_read,
    input  logic              pipe_hold,
    input  logic              flush_all,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic              sb_busy,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_br_stall_cnt
);

    localparam int unsigned CNT_W = $clog2(LOAD_LAT + 2);
    localparam int unsigned IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_DATA = 2'b01;
    localparam logic [1:0] CAUSE_BR   = 2'b10;
    localparam logic [1:0] CAUSE_FULL = 2'b11;

    logic [SB_DEPTH-1:0] entValid;
    logic [REG_AW-1:0]   entDst [SB_DEPTH];
    logic [CNT_W-1:0]    entCnt [SB_DEPTH];

    logic             useRs;
    logic             useRt;
    logic             anyMatch;
    logic             lateMatch;
    logic             anyFree;
    logic [IDX_W-1:0] freeIdx;
    logic             needAlloc;
    logic             doAlloc;
    logic [1:0]       causeC;

    // Source match against the scoreboard and lowest free entry search
    always_comb begin
        useRs     = id_use_rs && (id_rs != '0);
        useRt     = id_use_rt && (id_rt != '0);
        anyMatch  = 1'b0;
        lateMatch = 1'b0;
        anyFree   = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (entValid[i] && ((useRs && (entDst[i] == id_rs)) ||
                                (useRt && (entDst[i] == id_rt)))) begin
                anyMatch = 1'b1;
                if (entCnt[i] > CNT_W'(1)) begin
                    lateMatch = 1'b1;
                end
            end
        end
        for (int i = int'(SB_DEPTH) - 1; i >= 0; i--) begin
            if (!entValid[i]) begin
                anyFree = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    // Branches need the value in ID, so any live producer blocks them
    always_comb begin
        needAlloc = id_valid && id_wr_en && (id_wr_dst != '0);
        causeC    = CAUSE_NONE;
        if (id_is_branch && anyMatch) begin
            causeC = CAUSE_BR;
        end else if (!id_is_branch && lateMatch) begin
            causeC = CAUSE_DATA;
        end else if (needAlloc && !anyFree) begin
            causeC = CAUSE_FULL;
        end
        stall       = id_valid && (causeC != CAUSE_NONE);
        stall_cause = causeC;
        sb_busy     = |entValid;
        doAlloc     = needAlloc && !stall && !pipe_hold && !flush_all;
    end

    // Entries count down each advancing edge; the freed slot is only reusable next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entValid <= '0;
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                entDst[i] <= '0;
                entCnt[i] <= '0;
            end
        end else if (flush_all) begin
            entValid <= '0;
        end else if (!pipe_hold) begin
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                if (entValid[i]) begin
                    if (entCnt[i] == CNT_W'(1)) begin
                        entValid[i] <= 1'b0;
                    end else begin
                        entCnt[i] <= entCnt[i] - CNT_W'(1);
                    end
                end
            end
            if (doAlloc) begin
                entValid[freeIdx] <= 1'b1;
                entDst[freeIdx]   <= id_wr_dst;
                entCnt[freeIdx]   <= id_mem_read ? CNT_W'(LOAD_LAT + 1) : CNT_W'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] brStallCnt;

    // Saturating stall counters, advancing only on edges where the pipe moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt   <= '0;
            brStallCnt <= '0;
        end else if (stall && !pipe_hold && !flush_all) begin
            if (stallCnt != '1) begin
                stallCnt <= stallCnt + 32'd1;
            end
            if ((causeC == CAUSE_BR) && (brStallCnt != '1)) begin
                brStallCnt <= brStallCnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stallCnt;
    assign perf_br_stall_cnt = brStallCnt;
`else
    assign perf_stall_cnt    = '0;
    assign perf_br_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus two LOAD_LAT=3 instances for depth limits.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_branch;
    logic       id_wr_en;
    logic [4:0] id_wr_dst;
    logic       id_mem_read;
    logic       pipe_hold;
    logic       flush_all;

    logic        stall, sb_busy;
    logic [1:0]  cause;
    logic [31:0] perfAll, perfBr;
    logic        stall35, busy35;
    logic [1:0]  cause35;
    logic [31:0] perfAll35, perfBr35;
    logic        stall34, busy34;
    logic [1:0]  cause34;
    logic [31:0] perfAll34, perfBr34;

    int tests;
    int errors;

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .SB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst), .id_mem_read(id_mem_read),
        .pipe_hold(pipe_hold), .flush_all(flush_all), .stall(stall), .stall_cause(cause),
        .sb_busy(sb_busy), .perf_stall_cnt(perfAll), .perf_br_stall_cnt(perfBr)
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .SB_DEPTH(5)) dut35 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst), .id_mem_read(id_mem_read),
        .pipe_hold(pipe_hold), .flush_all(flush_all), .stall(stall35), .stall_cause(cause35),
        .sb_busy(busy35), .perf_stall_cnt(perfAll35), .perf_br_stall_cnt(perfBr35)
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .SB_DEPTH(4)) dut34 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst), .id_mem_read(id_mem_read),
        .pipe_hold(pipe_hold), .flush_all(flush_all), .stall(stall34), .stall_cause(cause34),
        .sb_busy(busy34), .perf_stall_cnt(perfAll34), .perf_br_stall_cnt(perfBr34)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic we, input logic [4:0] dst, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_is_branch = br; id_wr_en = we; id_wr_dst = dst; id_mem_read = mr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic load(input logic [4:0] dst);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, dst, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pipe_hold = 1'b0;
        flush_all = 1'b0;
        idle();
        settle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_hold = 1'b0;
        flush_all = 1'b0;
        drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
        settle();
        tests++;
        if ({stall, cause, sb_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b cause=%b busy=%b want 0/00/0", stall, cause, sb_busy);
        end
        tests++;
        if (perfAll !== 32'd0 || perfBr !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perfAll, perfBr);
        end
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        load(5'd8);
        settle();
        tests++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_load_issue: got stall=%b want 0", stall);
        end
        tick();
        drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        settle();
        tests++;
        if ({stall, cause, sb_busy} !== 4'b1011) begin
            errors++;
            $display("FAIL lu_stall1: got stall=%b cause=%b busy=%b want 1/01/1", stall, cause, sb_busy);
        end
        tick();
        settle();
        tests++;
        if ({stall, cause} !== 3'b000) begin
            errors++;
            $display("FAIL lu_issue: got stall=%b cause=%b want 0/00", stall, cause);
        end
        tests++;
        if (perfAll !== (PERF ? 32'd1 : 32'd0) || perfBr !== 32'd0) begin
            errors++;
            $display("FAIL lu_perf: got %0d/%0d want %0d/0", perfAll, perfBr, PERF ? 1 : 0);
        end
        tick();
        idle();
        settle();
        tests++;
        if (sb_busy !== 1'b1) begin
            errors++;
            $display("FAIL lu_alu_busy: got busy=%b want 1", sb_busy);
        end
        tick();
        settle();
        tests++;
        if (sb_busy !== 1'b0) begin
            errors++;
            $display("FAIL lu_drain: got busy=%b want 0", sb_busy);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        load(5'd8);
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            settle();
            tests++;
            if ({stall, cause} !== 3'b110) begin
                errors++;
                $display("FAIL lb_stall%0d: got stall=%b cause=%b want 1/10", c, stall, cause);
            end
            tick();
        end
        settle();
        tests++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lb_issue: got stall=%b want 0", stall);
        end
        tests++;
        if (perfAll !== (PERF ? 32'd2 : 32'd0) || perfBr !== (PERF ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL lb_perf: got %0d/%0d want %0d/%0d", perfAll, perfBr, PERF ? 2 : 0, PERF ? 2 : 0);
        end
        tick();
        idle();
    endtask

    task automatic test_alu_deps();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        settle();
        tests++;
        if ({stall, cause} !== 3'b110) begin
            errors++;
            $display("FAIL ab_stall: got stall=%b cause=%b want 1/10", stall, cause);
        end
        tick();
        settle();
        tests++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL ab_issue: got stall=%b want 0", stall);
        end
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        settle();
        tests++;
        if ({stall, cause, sb_busy} !== 4'b0001) begin
            errors++;
            $display("FAIL aa_nostall: got stall=%b cause=%b busy=%b want 0/00/1", stall, cause, sb_busy);
        end
        tick();
        idle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        load(5'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        settle();
        tests++;
        if ({stall, cause, sb_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL zero_reg: got stall=%b cause=%b busy=%b want 0/00/0", stall, cause, sb_busy);
        end
        tick();
        load(5'd8);
        tick();
        drive(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        settle();
        tests++;
        if ({stall, sb_busy} !== 2'b01) begin
            errors++;
            $display("FAIL unread_src: got stall=%b busy=%b want 0/1", stall, sb_busy);
        end
        tick();
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            load(5'(k));
            settle();
            tests++;
            if ({stall34, stall35, stall} !== 3'b000) begin
                errors++;
                $display("FAIL full_fill%0d: got s34=%b s35=%b s=%b want 0/0/0", k, stall34, stall35, stall);
            end
            tick();
        end
        load(5'd5);
        settle();
        tests++;
        if ({stall34, cause34} !== 3'b111) begin
            errors++;
            $display("FAIL full_d4: got stall=%b cause=%b want 1/11", stall34, cause34);
        end
        tests++;
        if ({stall35, cause35} !== 3'b000) begin
            errors++;
            $display("FAIL full_d5: got stall=%b cause=%b want 0/00", stall35, cause35);
        end
        tick();
        settle();
        tests++;
        if ({stall34, cause34} !== 3'b000) begin
            errors++;
            $display("FAIL full_retry: got stall=%b cause=%b want 0/00", stall34, cause34);
        end
        tick();
        idle();
    endtask

    task automatic test_pipe_hold();
        do_reset();
        load(5'd9);
        tick();
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
        pipe_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            tests++;
            if ({stall, cause} !== 3'b101) begin
                errors++;
                $display("FAIL hold_stall%0d: got stall=%b cause=%b want 1/01", c, stall, cause);
            end
            tick();
        end
        pipe_hold = 1'b0;
        settle();
        tests++;
        if ({stall, cause} !== 3'b101) begin
            errors++;
            $display("FAIL hold_release: got stall=%b cause=%b want 1/01", stall, cause);
        end
        tick();
        settle();
        tests++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL hold_issue: got stall=%b want 0", stall);
        end
        tests++;
        if (perfAll !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL hold_perf: got %0d want %0d", perfAll, PERF ? 1 : 0);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        load(5'd8);
        tick();
        load(5'd9);
        tick();
        idle();
        flush_all = 1'b1;
        settle();
        tests++;
        if (sb_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_before: got busy=%b want 1", sb_busy);
        end
        tick();
        flush_all = 1'b0;
        drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        settle();
        tests++;
        if ({stall, cause, sb_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_after: got stall=%b cause=%b busy=%b want 0/00/0", stall, cause, sb_busy);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load(5'd8);
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0);
        settle();
        tests++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rms_pre: got stall=%b want 1", stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({stall, cause, sb_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rms_drop: got stall=%b cause=%b busy=%b want 0/00/0", stall, cause, sb_busy);
        end
        tick();
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_deps();
        test_zero_reg();
        test_full();
        test_pipe_hold();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
